// File: rtl/bpsk_modulator_writer.sv
// BPSK modulator writer: maps a captured LDPC codeword to +/-Amplitude symbols and streams them two per cycle into the modulation RAM.
// Optional macro AWGN_NOISE_EN adds LFSR-based pseudo-noise with saturation to each symbol.
module bpsk_modulator_writer #(
    parameter int unsigned CodeLen      = 256,
    parameter int unsigned CodeLen_bits = 8,
    parameter logic [14:0] Amplitude    = 15'd1024,
    parameter int unsigned NoiseShift   = 4,
    parameter logic [31:0] NoiseSeed    = 32'hACE1_2468
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    codeword_valid,
    input  logic [CodeLen-1:0]      codeword,
    output logic                    codeword_ready,
    output logic                    write_enable_a,
    output logic                    write_enable_b,
    output logic [CodeLen_bits:0]   modulation_i,
    output logic [14:0]             modulation_sequence_after_a,
    output logic [14:0]             modulation_sequence_after_b,
    output logic                    modulation_write_down,
    input  logic                    modulation_release
);

    localparam int unsigned IW = CodeLen_bits + 1;
    localparam int unsigned SW = 15;
    localparam logic [IW-1:0] LastIdx = IW'(CodeLen);
    localparam logic [IW-1:0] PairStep = IW'(2);
    localparam logic [SW-1:0] SymPos = Amplitude;
    localparam logic [SW-1:0] SymNeg = SW'(~Amplitude + 15'd1);

    // Elaboration-time parameter sanity
    if (CodeLen % 2 != 0) begin : g_odd_len
        $error("CodeLen must be even");
    end
    if (NoiseSeed == 32'd0) begin : g_zero_seed
        $error("NoiseSeed must be non-zero");
    end
    if (NoiseShift > 15) begin : g_bad_shift
        $error("NoiseShift must be at most 15");
    end

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [CodeLen-1:0]  shreg_q, shreg_d;
    logic                we_d;
    logic [IW-1:0]       idx_d;
    logic [SW-1:0]       sym_a_d, sym_b_d;
    logic                wd_d;
    logic [1:0]          src_bits;
    logic [SW-1:0]       sym_a_next, sym_b_next;

    assign codeword_ready = (state_q == IDLE);

    // Bits for the next pair: straight from the input on capture, else from the shift register
    assign src_bits = (state_q == IDLE) ? codeword[1:0] : shreg_q[1:0];

`ifdef AWGN_NOISE_EN
    logic [31:0] lfsr_q;
    logic [15:0] noise_a, noise_b;

    // Fibonacci LFSR x^32+x^22+x^2+x+1, advances only on cycles that register a pair
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= NoiseSeed;
        end else if (we_d) begin
            lfsr_q <= {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        end
    end

    assign noise_a = 16'($signed(lfsr_q[15:0]) >>> NoiseShift);
    assign noise_b = 16'($signed(lfsr_q[31:16]) >>> NoiseShift);

    function automatic logic [SW-1:0] map_sym(input logic b, input logic [15:0] noise);
        logic signed [16:0] base;
        logic signed [16:0] sum;
        base = $signed({2'b00, Amplitude});
        if (b) begin
            base = -base;
        end
        sum = base + $signed({noise[15], noise});
        if (sum > 17'sd16383) begin
            return 15'h3FFF;
        end else if (sum < -17'sd16384) begin
            return 15'h4000;
        end else begin
            return sum[14:0];
        end
    endfunction

    assign sym_a_next = map_sym(src_bits[0], noise_a);
    assign sym_b_next = map_sym(src_bits[1], noise_b);
`else
    function automatic logic [SW-1:0] map_sym(input logic b);
        return b ? SymNeg : SymPos;
    endfunction

    assign sym_a_next = map_sym(src_bits[0]);
    assign sym_b_next = map_sym(src_bits[1]);
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        we_d    = 1'b0;
        idx_d   = modulation_i;
        sym_a_d = modulation_sequence_after_a;
        sym_b_d = modulation_sequence_after_b;
        wd_d    = modulation_write_down;

        unique case (state_q)
            IDLE: begin
                if (codeword_valid) begin
                    state_d = WRITE;
                    shreg_d = codeword >> 2;
                    we_d    = 1'b1;
                    idx_d   = PairStep;
                    sym_a_d = sym_a_next;
                    sym_b_d = sym_b_next;
                end
            end
            WRITE: begin
                if (modulation_i == LastIdx) begin
                    state_d = DONE;
                    wd_d    = 1'b1;
                end else begin
                    shreg_d = shreg_q >> 2;
                    we_d    = 1'b1;
                    idx_d   = modulation_i + PairStep;
                    sym_a_d = sym_a_next;
                    sym_b_d = sym_b_next;
                end
            end
            DONE: begin
                if (modulation_release) begin
                    state_d = IDLE;
                    wd_d    = 1'b0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered datapath and RAM-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q                     <= '0;
            write_enable_a              <= 1'b0;
            write_enable_b              <= 1'b0;
            modulation_i                <= '0;
            modulation_sequence_after_a <= '0;
            modulation_sequence_after_b <= '0;
            modulation_write_down       <= 1'b0;
        end else begin
            shreg_q                     <= shreg_d;
            write_enable_a              <= we_d;
            write_enable_b              <= we_d;
            modulation_i                <= idx_d;
            modulation_sequence_after_a <= sym_a_d;
            modulation_sequence_after_b <= sym_b_d;
            modulation_write_down       <= wd_d;
        end
    end

endmodule

// File: tb/tb_bpsk_modulator_writer.sv
// Scoreboard bench for bpsk_modulator_writer: stimulus queues expected RAM writes, a negedge monitor pops and compares them.
module tb_bpsk_modulator_writer;

    localparam int unsigned CL = 256;
    localparam int unsigned CB = 8;
    localparam logic [14:0] POS = 15'h0400;
    localparam logic [14:0] NEG = 15'h7C00;

    typedef struct packed {
        logic [CB:0] idx;
        logic [14:0] a;
        logic [14:0] b;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          codeword_valid;
    logic [CL-1:0] codeword;
    logic          codeword_ready;
    logic          write_enable_a;
    logic          write_enable_b;
    logic [CB:0]   modulation_i;
    logic [14:0]   modulation_sequence_after_a;
    logic [14:0]   modulation_sequence_after_b;
    logic          modulation_write_down;
    logic          modulation_release;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bpsk_modulator_writer dut (
        .clk                         (clk),
        .rst                         (rst),
        .codeword_valid              (codeword_valid),
        .codeword                    (codeword),
        .codeword_ready              (codeword_ready),
        .write_enable_a              (write_enable_a),
        .write_enable_b              (write_enable_b),
        .modulation_i                (modulation_i),
        .modulation_sequence_after_a (modulation_sequence_after_a),
        .modulation_sequence_after_b (modulation_sequence_after_b),
        .modulation_write_down       (modulation_write_down),
        .modulation_release          (modulation_release)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst === 1'b1 && (write_enable_a || write_enable_b)) begin
            chk("we_a", 32'(write_enable_a), 32'd1);
            chk("we_b", 32'(write_enable_b), 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_write_idx", 32'(modulation_i), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("write_idx", 32'(modulation_i), 32'(e.idx));
                chk("sym_a", 32'(modulation_sequence_after_a), 32'(e.a));
                chk("sym_b", 32'(modulation_sequence_after_b), 32'(e.b));
            end
        end
    end

    task automatic push_cw(input logic [CL-1:0] cw);
        for (int k = 0; k < CL / 2; k++) begin
            exp_t e;
            e.idx = (CB + 1)'(2 * k + 2);
            e.a   = cw[2 * k] ? NEG : POS;
            e.b   = cw[2 * k + 1] ? NEG : POS;
            exp_q.push_back(e);
        end
    endtask

    // Present a codeword for one edge; returns #1 after the capture edge
    task automatic capture(input logic [CL-1:0] cw);
        push_cw(cw);
        @(negedge clk);
        chk("ready_before_capture", 32'(codeword_ready), 32'd1);
        codeword       = cw;
        codeword_valid = 1'b1;
        @(posedge clk);
        #1;
        codeword_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_edges);
        int k;
        k = 0;
        while (!modulation_write_down && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("done_latency", 32'(k), 32'(exp_edges));
        chk("done_we", 32'(write_enable_a), 32'd0);
        chk("done_idx", 32'(modulation_i), 32'(CL));
        chk("done_ready", 32'(codeword_ready), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic release_buf();
        @(negedge clk);
        modulation_release = 1'b1;
        @(posedge clk);
        #1;
        modulation_release = 1'b0;
        chk("rel_wd", 32'(modulation_write_down), 32'd0);
        chk("rel_idx", 32'(modulation_i), 32'd0);
        chk("rel_ready", 32'(codeword_ready), 32'd1);
    endtask

    initial begin
        logic [CL-1:0] cw0, cw1, cw2, cw4, cw5;
        int k;
        cw0 = '0;
        cw1 = {128{2'b10}};
        cw2 = {4{64'h0123_4567_89AB_CDEF}};
        cw4 = {8{32'hF0F0_A55A}};
        cw5 = '1;

        rst                = 1'b0;
        codeword_valid     = 1'b0;
        codeword           = '0;
        modulation_release = 1'b0;
        #3;
        chk("rst_ready", 32'(codeword_ready), 32'd1);
        chk("rst_we", 32'({write_enable_a, write_enable_b}), 32'd0);
        chk("rst_idx", 32'(modulation_i), 32'd0);
        chk("rst_syms", 32'({modulation_sequence_after_a, modulation_sequence_after_b}), 32'd0);
        chk("rst_wd", 32'(modulation_write_down), 32'd0);
        #19;
        rst = 1'b1;

        // Idle: any strobe hits an empty queue in the monitor
        repeat (100) @(posedge clk);
        #1;
        chk("idle_ready", 32'(codeword_ready), 32'd1);
        chk("idle_wd", 32'(modulation_write_down), 32'd0);
        chk("idle_idx", 32'(modulation_i), 32'd0);

        capture(cw0);
        wait_done(128);
        release_buf();

        capture(cw1);
        wait_done(128);
        release_buf();

        // Release pulsed while writing must be ignored
        capture(cw2);
        @(posedge clk);
        #1;
        modulation_release = 1'b1;
        @(posedge clk);
        #1;
        modulation_release = 1'b0;
        wait_done(126);

        // Valid held in DONE: no capture until one edge after release
        codeword       = cw4;
        codeword_valid = 1'b1;
        push_cw(cw4);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("done_hold_wd", 32'(modulation_write_down), 32'd1);
            chk("done_hold_ready", 32'(codeword_ready), 32'd0);
        end
        modulation_release = 1'b1;
        @(posedge clk);
        #1;
        modulation_release = 1'b0;
        chk("held_rel_wd", 32'(modulation_write_down), 32'd0);
        chk("held_rel_we", 32'(write_enable_a), 32'd0);
        chk("held_rel_idx", 32'(modulation_i), 32'd0);
        @(posedge clk);
        #1;
        codeword_valid = 1'b0;
        chk("held_cap_we", 32'(write_enable_a), 32'd1);
        chk("held_cap_idx", 32'(modulation_i), 32'd2);
        wait_done(128);
        release_buf();

        // Asynchronous reset in the middle of a codeword
        capture(cw2);
        k = 0;
        while (modulation_i != (CB + 1)'(100) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("reach_idx_100", 32'(modulation_i), 32'd100);
        rst = 1'b0;
        #1;
        chk("async_ready", 32'(codeword_ready), 32'd1);
        chk("async_we", 32'({write_enable_a, write_enable_b}), 32'd0);
        chk("async_idx", 32'(modulation_i), 32'd0);
        chk("async_syms", 32'({modulation_sequence_after_a, modulation_sequence_after_b}), 32'd0);
        chk("async_wd", 32'(modulation_write_down), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b1;

        capture(cw5);
        wait_done(128);
        release_buf();

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
